// File: rtl/packet_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// packet_unpacker_pkg: shared NIC widths, flit layout, CTI codes and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package packet_unpacker_pkg;

  localparam int BUS_ADDRESS_WIDTH  = 32;
  localparam int BUS_DATA_WIDTH     = 32;
  localparam int BUS_SEL_WIDTH      = BUS_DATA_WIDTH / 8;
  localparam int BUS_BYTES          = BUS_DATA_WIDTH / 8;

  // Flit = {type, payload}. Head payload: {rsvd, len-1, cmd(WE), addr};
  // body payload: {rsvd, sel, data}, one body flit per burst chunk.
  localparam int FLIT_TYPE_BITS     = 2;
  localparam int FLIT_PAYLOAD_WIDTH = 40;
  localparam int FLIT_WIDTH         = FLIT_TYPE_BITS + FLIT_PAYLOAD_WIDTH;
  localparam int CMD_BITS_HEAD_FLIT = 1;
  localparam int HEAD_CMD_LSB       = BUS_ADDRESS_WIDTH;
  localparam int HEAD_LEN_LSB       = HEAD_CMD_LSB + CMD_BITS_HEAD_FLIT;
  localparam int BODY_SEL_LSB       = BUS_DATA_WIDTH;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/packet_unpacker_pkt_to_msg.sv
// ---------------------------------------------------------------------------
// packet_unpacker_pkt_to_msg: combinational flit-vector to bus-message decode.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module packet_unpacker_pkt_to_msg
  import packet_unpacker_pkg::*;
#(
  parameter  int N_BITS_BURST_LENGHT = 5,
  localparam int MAX_BURST_LENGHT    = 1 << N_BITS_BURST_LENGHT,
  localparam int MAX_PACKET_LENGHT   = MAX_BURST_LENGHT + 1
) (
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0]   i_pkt,
  output logic [BUS_ADDRESS_WIDTH-1:0]              o_addr,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] o_data,
  output logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]  o_sel,
  output logic                                      o_we,
  output logic [N_BITS_BURST_LENGHT:0]              o_n_chunk
);

  logic [FLIT_WIDTH-1:0] w_head;
  logic                  w_unused_pkt;

  assign w_head    = i_pkt[FLIT_WIDTH-1:0];
  assign o_addr    = w_head[BUS_ADDRESS_WIDTH-1:0];
  assign o_we      = w_head[HEAD_CMD_LSB];
  // Length field carries n_chunk-1 so a full-size burst fits the field.
  assign o_n_chunk = {1'b0, w_head[HEAD_LEN_LSB +: N_BITS_BURST_LENGHT]}
                   + (N_BITS_BURST_LENGHT+1)'(1);

  for (genvar k = 0; k < MAX_BURST_LENGHT; k++) begin : g_chunk
    localparam int FLIT_LSB = (k + 1) * FLIT_WIDTH;
    assign o_data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = i_pkt[FLIT_LSB +: BUS_DATA_WIDTH];
    assign o_sel[k*BUS_SEL_WIDTH +: BUS_SEL_WIDTH]    = i_pkt[FLIT_LSB + BODY_SEL_LSB +: BUS_SEL_WIDTH];
  end

  // Flit type and reserved bits are routing information only.
  assign w_unused_pkt = ^i_pkt;

endmodule

`default_nettype wire

// File: rtl/packet_unpacker.sv
// ---------------------------------------------------------------------------
// packet_unpacker: replays one network packet as a Wishbone burst, returns read data.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module packet_unpacker
  import packet_unpacker_pkg::*;
#(
  parameter  int N_BITS_VNET_ID      = 2,
  parameter  int N_BITS_BURST_LENGHT = 5,
  localparam int MAX_BURST_LENGHT    = 1 << N_BITS_BURST_LENGHT,
  localparam int MAX_PACKET_LENGHT   = MAX_BURST_LENGHT + 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0]    pkt_i,
  input  logic [N_BITS_VNET_ID-1:0]                  vnet_id_i,
  input  logic                                       is_valid_i,
  output logic                                       ready_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]               ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]                  DAT_O,
  output logic [BUS_SEL_WIDTH-1:0]                   SEL_O,
  output logic                                       WE_O,
  output logic                                       CYC_O,
  output logic                                       STB_O,
  output logic [2:0]                                 CTI_O,
  input  logic [BUS_DATA_WIDTH-1:0]                  DAT_I,
  input  logic                                       ACK_I,
  input  logic                                       ERR_I,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] reply_data_o,
  output logic [N_BITS_BURST_LENGHT:0]               reply_n_chunk_o,
  output logic [N_BITS_VNET_ID-1:0]                  reply_vnet_id_o,
  output logic                                       reply_valid_o,
  input  logic                                       reply_ack_i,
  output logic                                       error_o
);

  localparam logic [N_BITS_BURST_LENGHT:0]   ONE_CHUNK = (N_BITS_BURST_LENGHT+1)'(1);
  localparam logic [N_BITS_BURST_LENGHT-1:0] IDX_ONE   = N_BITS_BURST_LENGHT'(1);

  state_t r_state;
  state_t w_state_next;

  logic [BUS_ADDRESS_WIDTH-1:0]                         r_addr;
  logic [MAX_BURST_LENGHT-1:0][BUS_DATA_WIDTH-1:0]      r_data;
  logic [MAX_BURST_LENGHT-1:0][BUS_SEL_WIDTH-1:0]       r_sel;
  logic [MAX_BURST_LENGHT-1:0][BUS_DATA_WIDTH-1:0]      r_reply;
  logic                                                 r_we;
  logic [N_BITS_BURST_LENGHT:0]                         r_n_chunk;
  logic [N_BITS_BURST_LENGHT-1:0]                       r_idx;
  logic [N_BITS_VNET_ID-1:0]                            r_vnet;
  logic                                                 r_err;

  logic [BUS_ADDRESS_WIDTH-1:0]                         w_dec_addr;
  logic [MAX_BURST_LENGHT-1:0][BUS_DATA_WIDTH-1:0]      w_dec_data;
  logic [MAX_BURST_LENGHT-1:0][BUS_SEL_WIDTH-1:0]       w_dec_sel;
  logic                                                 w_dec_we;
  logic [N_BITS_BURST_LENGHT:0]                         w_dec_n_chunk;

  logic                                                 w_last;
  logic                                                 w_accept;
  logic [BUS_ADDRESS_WIDTH-1:0]                         w_offset;

  packet_unpacker_pkt_to_msg #(
    .N_BITS_BURST_LENGHT (N_BITS_BURST_LENGHT)
  ) u_pkt_to_msg (
    .i_pkt     (pkt_i),
    .o_addr    (w_dec_addr),
    .o_data    (w_dec_data),
    .o_sel     (w_dec_sel),
    .o_we      (w_dec_we),
    .o_n_chunk (w_dec_n_chunk)
  );

  assign w_last   = ({1'b0, r_idx} == (r_n_chunk - ONE_CHUNK));
  assign w_accept = is_valid_i && ready_o;
  // Address arithmetic is deliberately modulo the bus width so bursts wrap.
  assign w_offset = BUS_ADDRESS_WIDTH'(r_idx) * BUS_ADDRESS_WIDTH'(BUS_BYTES);

  assign reply_data_o    = r_reply;
  assign reply_n_chunk_o = r_n_chunk;
  assign reply_vnet_id_o = r_vnet;
  assign error_o         = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    ready_o       = 1'b0;
    CYC_O         = 1'b0;
    STB_O         = 1'b0;
    WE_O          = 1'b0;
    ADR_O         = '0;
    DAT_O         = '0;
    SEL_O         = '0;
    CTI_O         = CTI_CLASSIC;
    reply_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (is_valid_i) w_state_next = ST_BUS;
      end
      ST_BUS: begin
        CYC_O = 1'b1;
        STB_O = 1'b1;
        WE_O  = r_we;
        ADR_O = r_addr + w_offset;
        DAT_O = r_data[r_idx];
        SEL_O = r_sel[r_idx];
        if (r_n_chunk != ONE_CHUNK) CTI_O = w_last ? CTI_END : CTI_INCR;
        if (ERR_I) begin
          w_state_next = ST_IDLE;
        end else if (ACK_I && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A finished write has nothing to return, so it is as good as idle.
        if (r_we) begin
          ready_o      = 1'b1;
          w_state_next = is_valid_i ? ST_BUS : ST_IDLE;
        end else begin
          reply_valid_o = 1'b1;
          if (reply_ack_i) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_sel     <= '0;
      r_reply   <= '0;
      r_we      <= 1'b0;
      r_n_chunk <= '0;
      r_idx     <= '0;
      r_vnet    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= (r_state == ST_BUS) && ERR_I;
      if (w_accept) begin
        r_addr    <= w_dec_addr;
        r_data    <= w_dec_data;
        r_sel     <= w_dec_sel;
        r_we      <= w_dec_we;
        r_n_chunk <= w_dec_n_chunk;
        r_vnet    <= vnet_id_i;
        r_idx     <= '0;
        r_reply   <= '0;
      end else if ((r_state == ST_BUS) && !ERR_I && ACK_I) begin
        if (!r_we) r_reply[r_idx] <= DAT_I;
        if (!w_last) r_idx <= r_idx + IDX_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_unpacker.sv
// ---------------------------------------------------------------------------
// tb_packet_unpacker: randomized Wishbone-slave bench with a message-level reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_packet_unpacker;

  localparam int FW    = 42;
  localparam int MAXB  = 32;
  localparam int PKT_W = (MAXB + 1) * FW;

  typedef struct {
    logic [31:0]            addr;
    bit                     we;
    int                     n;
    logic [1:0]             vnet;
    logic [31:0][31:0]      data;
    logic [31:0][3:0]       sel;
  } msg_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [PKT_W-1:0]  pkt_i;
  logic [1:0]        vnet_id_i;
  logic              is_valid_i;
  logic              ready_o;
  logic [31:0]       ADR_O;
  logic [31:0]       DAT_O;
  logic [3:0]        SEL_O;
  logic              WE_O;
  logic              CYC_O;
  logic              STB_O;
  logic [2:0]        CTI_O;
  logic [31:0]       DAT_I;
  logic              ACK_I;
  logic              ERR_I;
  logic [MAXB*32-1:0] reply_data_o;
  logic [5:0]        reply_n_chunk_o;
  logic [1:0]        reply_vnet_id_o;
  logic              reply_valid_o;
  logic              reply_ack_i;
  logic              error_o;

  int n_tests = 0;
  int n_fail  = 0;

  packet_unpacker #(
    .N_BITS_VNET_ID      (2),
    .N_BITS_BURST_LENGHT (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pkt_i           (pkt_i),
    .vnet_id_i       (vnet_id_i),
    .is_valid_i      (is_valid_i),
    .ready_o         (ready_o),
    .ADR_O           (ADR_O),
    .DAT_O           (DAT_O),
    .SEL_O           (SEL_O),
    .WE_O            (WE_O),
    .CYC_O           (CYC_O),
    .STB_O           (STB_O),
    .CTI_O           (CTI_O),
    .DAT_I           (DAT_I),
    .ACK_I           (ACK_I),
    .ERR_I           (ERR_I),
    .reply_data_o    (reply_data_o),
    .reply_n_chunk_o (reply_n_chunk_o),
    .reply_vnet_id_o (reply_vnet_id_o),
    .reply_valid_o   (reply_valid_o),
    .reply_ack_i     (reply_ack_i),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packet encoder: head {type, rsvd, len-1, we, addr}, body {type, rsvd, sel, data}.
  function automatic logic [PKT_W-1:0] build_pkt(input msg_t m);
    logic [PKT_W-1:0] p;
    logic [4:0]       len;
    logic [1:0]       ftype;
    p   = '0;
    len = 5'(m.n - 1);
    p[FW-1:0] = {2'b10, 2'b00, len, m.we, m.addr};
    for (int k = 0; k < m.n; k++) begin
      ftype = (k == m.n - 1) ? 2'b01 : 2'b00;
      p[(k+1)*FW +: FW] = {ftype, 4'($urandom), m.sel[k], m.data[k]};
    end
    return p;
  endfunction

  function automatic msg_t rand_msg(input int n, input bit we);
    msg_t m;
    m.addr = $urandom;
    m.we   = we;
    m.n    = n;
    m.vnet = 2'($urandom);
    for (int k = 0; k < MAXB; k++) begin
      m.data[k] = $urandom;
      m.sel[k]  = 4'($urandom);
    end
    return m;
  endfunction

  task automatic check_bus(input msg_t m, input int i);
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    exp_adr = m.addr + 32'(i * 4);
    if (m.n == 1)          exp_cti = 3'b000;
    else if (i == m.n - 1) exp_cti = 3'b111;
    else                   exp_cti = 3'b010;
    check("bus_cyc",  CYC_O,   1);
    check("bus_stb",  STB_O,   1);
    check("bus_we",   WE_O,    m.we);
    check("bus_adr",  ADR_O,   exp_adr);
    check("bus_dat",  DAT_O,   m.data[i]);
    check("bus_sel",  SEL_O,   m.sel[i]);
    check("bus_cti",  CTI_O,   exp_cti);
    check("bus_busy", ready_o, 0);
  endtask

  // Starts and ends on a falling edge. err_at/rst_at select the beat at which
  // ERR_I or an asynchronous reset is injected (-1 = never).
  task automatic run_msg(input msg_t m, input int wmin, input int wmax, input int err_at,
                         input int rst_at, input bit seq_rd, input bit hold, input msg_t nxt);
    logic [31:0] exp_rd [MAXB];
    int guard;
    int w;
    for (int k = 0; k < MAXB; k++) exp_rd[k] = '0;
    guard = 0;
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", ready_o, 1);
    pkt_i      = build_pkt(m);
    vnet_id_i  = m.vnet;
    is_valid_i = 1'b1;
    @(negedge clk);
    if (hold) begin
      pkt_i     = build_pkt(nxt);
      vnet_id_i = nxt.vnet;
    end else begin
      is_valid_i = 1'b0;
    end
    check("first_stb", STB_O, 1);
    for (int i = 0; i < m.n; i++) begin
      w = $urandom_range(wmax, wmin);
      for (int c = 0; c <= w; c++) begin
        check_bus(m, i);
        if (i == rst_at) begin
          #2 rst = 1'b0;
          #1;
          check("rst_cyc",   CYC_O,   0);
          check("rst_stb",   STB_O,   0);
          check("rst_ready", ready_o, 1);
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          check("rst_idle_stb",   STB_O,         0);
          check("rst_no_reply",   reply_valid_o, 0);
          return;
        end
        reply_ack_i = 1'($urandom);
        if (c == w) begin
          ACK_I = 1'b1;
          if (i == err_at) begin
            ERR_I = 1'b1;
          end else begin
            DAT_I = seq_rd ? 32'(i + 1) : $urandom;
            if (!m.we) exp_rd[i] = DAT_I;
          end
        end
        @(negedge clk);
        ACK_I       = 1'b0;
        ERR_I       = 1'b0;
        reply_ack_i = 1'b0;
        DAT_I       = $urandom;
      end
      if (i == err_at) begin
        check("err_cyc",      CYC_O,         0);
        check("err_pulse",    error_o,       1);
        check("err_no_reply", reply_valid_o, 0);
        check("err_ready",    ready_o,       1);
        @(negedge clk);
        check("err_pulse_end", error_o, 0);
        check("err_no_reply2", reply_valid_o, 0);
        return;
      end
    end
    check("end_cyc", CYC_O, 0);
    check("end_err", error_o, 0);
    if (m.we) begin
      check("wr_ready",    ready_o,       1);
      check("wr_no_reply", reply_valid_o, 0);
    end else begin
      check("rd_valid", reply_valid_o,   1);
      check("rd_n",     reply_n_chunk_o, m.n);
      check("rd_vnet",  reply_vnet_id_o, m.vnet);
      check("rd_busy",  ready_o,         0);
      for (int k = 0; k < MAXB; k++)
        check($sformatf("rd_chunk%0d", k), reply_data_o[k*32 +: 32], exp_rd[k]);
      w = $urandom_range(2, 0);
      repeat (w) begin
        @(negedge clk);
        check("rd_hold", reply_valid_o, 1);
      end
      reply_ack_i = 1'b1;
      @(negedge clk);
      reply_ack_i = 1'b0;
      check("rd_clear", reply_valid_o, 0);
      check("rd_ready", ready_o,       1);
    end
  endtask

  initial begin
    msg_t m;
    msg_t b;
    msg_t none;
    rst         = 1'b0;
    pkt_i       = '0;
    vnet_id_i   = '0;
    is_valid_i  = 1'b0;
    DAT_I       = '0;
    ACK_I       = 1'b0;
    ERR_I       = 1'b0;
    reply_ack_i = 1'b0;
    none        = rand_msg(1, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", ready_o,       1);
    check("rst_cyc",   CYC_O,         0);
    check("rst_stb",   STB_O,         0);
    check("rst_we",    WE_O,          0);
    check("rst_adr",   ADR_O,         0);
    check("rst_dat",   DAT_O,         0);
    check("rst_sel",   SEL_O,         0);
    check("rst_cti",   CTI_O,         0);
    check("rst_reply", reply_valid_o, 0);
    check("rst_err",   error_o,       0);

    // Single write, two wait states.
    m = rand_msg(1, 1);
    m.addr = 32'h100; m.data[0] = 32'hDEADBEEF; m.sel[0] = 4'hF;
    run_msg(m, 2, 2, -1, -1, 0, 0, none);

    // Four-chunk read, zero wait states, DAT_I 1..4.
    m = rand_msg(4, 0);
    m.addr = 32'h200;
    run_msg(m, 0, 0, -1, -1, 1, 0, none);

    // Address wrap.
    m = rand_msg(2, 0);
    m.addr = 32'hFFFFFFFC;
    run_msg(m, 0, 1, -1, -1, 0, 0, none);

    // ERR_I together with ACK_I on the second chunk of a write.
    m = rand_msg(4, 1);
    run_msg(m, 0, 1, 1, -1, 0, 0, none);

    // Reset during chunk 3 of an 8-chunk read, then a fresh write.
    m = rand_msg(8, 0);
    run_msg(m, 0, 1, -1, 2, 0, 0, none);
    m = rand_msg(1, 1);
    run_msg(m, 0, 1, -1, -1, 0, 0, none);

    // Source holds the next packet while the block is busy.
    m = rand_msg(3, 1);
    b = rand_msg(2, 0);
    run_msg(m, 0, 2, -1, -1, 0, 1, b);
    run_msg(b, 0, 2, -1, -1, 0, 0, none);
    repeat (2) begin
      @(negedge clk);
      check("once_stb",   STB_O,   0);
      check("once_ready", ready_o, 1);
    end

    // Full-length read burst.
    m = rand_msg(MAXB, 0);
    run_msg(m, 0, 1, -1, -1, 0, 0, none);

    for (int t = 0; t < 25; t++) begin
      int n;
      n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(MAXB, 1)) : int'($urandom_range(6, 1));
      m = rand_msg(n, 1'($urandom));
      run_msg(m, 0, 2, -1, -1, 0, 0, none);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
